// File: rtl/rob_wb_arb_if.sv
// Result payload shared by execution units and the ROB, plus the writeback bus bundle
// carrying per-source push handshakes and the single retire-side result port.
package rob_defs;
    typedef struct packed {
        logic [5:0]  rob_idx;
        logic        exc;
        logic [31:0] data;
    } t_rob_result;
endpackage

interface rob_wb_arb_if #(
    parameter int NUM_SRCS = 3
);
    logic [NUM_SRCS-1:0]                  ex_valid_rb0;
    rob_defs::t_rob_result [NUM_SRCS-1:0] ex_result_rb0;
    logic [NUM_SRCS-1:0]                  ex_ready_rb0;
    logic                                 ro_valid_rb0;
    rob_defs::t_rob_result                ro_result_rb0;

    modport master (
        output ex_valid_rb0, ex_result_rb0,
        input  ex_ready_rb0, ro_valid_rb0, ro_result_rb0
    );

    modport slave (
        input  ex_valid_rb0, ex_result_rb0,
        output ex_ready_rb0, ro_valid_rb0, ro_result_rb0
    );
endinterface

// File: rtl/rob_wb_arb.sv
// Writeback arbiter: one small FIFO per execution unit, round-robin drain of one
// result per cycle into a registered ROB result port; flush discards everything queued.
module rob_wb_arb #(
    parameter int NUM_SRCS   = 3,
    parameter int FIFO_DEPTH = 2
) (
    input logic         clk,
    input logic         reset,
    input logic         flush_rb1,
    rob_wb_arb_if.slave bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int RW = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;

    localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST     = PW'(FIFO_DEPTH - 1);
    localparam logic [RW-1:0] LAST_SRC = RW'(NUM_SRCS - 1);
    localparam logic [RW:0]   NSRC     = (RW + 1)'(NUM_SRCS);

    rob_defs::t_rob_result mem [NUM_SRCS][FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr [NUM_SRCS];
    logic [PW-1:0]         wr_ptr [NUM_SRCS];
    logic [CW-1:0]         count  [NUM_SRCS];
    logic [RW-1:0]         rr_ptr;

    logic                  ro_valid;
    rob_defs::t_rob_result ro_result;

    logic [NUM_SRCS-1:0]   ready;
    logic [NUM_SRCS-1:0]   push;
    logic [NUM_SRCS-1:0]   pop;
    logic                  gnt_valid;
    logic [RW-1:0]         gnt_idx;
    logic [RW:0]           scan;

    // Ready depends only on the registered fill level, so a full FIFO never admits a push
    // even when it is being drained in the same cycle.
    always_comb begin
        for (int i = 0; i < NUM_SRCS; i++) begin
            ready[i] = !reset && (count[i] != FULL);
            push[i]  = bus.ex_valid_rb0[i] && ready[i] && !flush_rb1;
        end
    end

    // Scan downward so the last hit is the non-empty source closest to rr_ptr.
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        scan      = '0;
        for (int k = NUM_SRCS - 1; k >= 0; k--) begin
            scan = {1'b0, rr_ptr} + (RW + 1)'(k);
            if (scan >= NSRC) scan = scan - NSRC;
            if (!reset && !flush_rb1 && (count[scan[RW-1:0]] != '0)) begin
                gnt_valid = 1'b1;
                gnt_idx   = scan[RW-1:0];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SRCS; i++) begin
            pop[i] = gnt_valid && (gnt_idx == RW'(i));
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRCS; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
            rr_ptr    <= '0;
            ro_valid  <= 1'b0;
            ro_result <= '0;
        end else if (flush_rb1) begin
            for (int i = 0; i < NUM_SRCS; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
            ro_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SRCS; i++) begin
                if (push[i]) wr_ptr[i] <= (wr_ptr[i] == LAST) ? '0 : wr_ptr[i] + PW'(1);
                if (pop[i])  rd_ptr[i] <= (rd_ptr[i] == LAST) ? '0 : rd_ptr[i] + PW'(1);
                if (push[i] && !pop[i])      count[i] <= count[i] + CW'(1);
                else if (pop[i] && !push[i]) count[i] <= count[i] - CW'(1);
            end
            ro_valid <= gnt_valid;
            if (gnt_valid) begin
                ro_result <= mem[gnt_idx][rd_ptr[gnt_idx]];
                rr_ptr    <= (gnt_idx == LAST_SRC) ? '0 : gnt_idx + RW'(1);
            end
        end
    end

    // NOTE: payload storage is not reset; count alone decides which entries are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRCS; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= bus.ex_result_rb0[i];
        end
    end

    assign bus.ex_ready_rb0  = ready;
    assign bus.ro_valid_rb0  = ro_valid;
    assign bus.ro_result_rb0 = ro_result;

`ifdef ASSERT
    for (genvar i = 0; i < NUM_SRCS; i++) begin : g_push_chk
        a_push_when_ready: assert property (@(posedge clk) disable iff (reset)
            !(bus.ex_valid_rb0[i] && !ready[i]));
    end
`endif

endmodule

// File: tb/tb_rob_wb_arb.sv
// Bench for rob_wb_arb: directed vector table, hand-written corner sequences, and a
// randomized run, all compared against a queue-based reference model.
module tb_rob_wb_arb;
    import rob_defs::*;

    localparam int N = 3;
    localparam int D = 2;

    logic clk = 1'b0;
    logic reset;
    logic flush_rb1;

    rob_wb_arb_if #(.NUM_SRCS(N)) bus ();

    rob_wb_arb #(.NUM_SRCS(N), .FIFO_DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush_rb1 (flush_rb1),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one queue per source, integer round-robin pointer.
    t_rob_result mq [N][$];
    int          m_rr;
    logic        m_valid;
    t_rob_result m_result;

    function automatic t_rob_result mk(input int id);
        t_rob_result r;
        r.rob_idx = 6'(id);
        r.exc     = id[0];
        r.data    = 32'hC0DE_0000 ^ 32'(id);
        return r;
    endfunction

    function automatic int id_of(input t_rob_result r);
        return int'(r.data ^ 32'hC0DE_0000);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model(input logic [N-1:0] v, input logic fl, input logic rs);
        int sz [N];
        int g;
        for (int i = 0; i < N; i++) sz[i] = mq[i].size();
        if (rs || fl) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_valid = 1'b0;
            if (rs) begin
                m_rr     = 0;
                m_result = '0;
            end
        end else begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && mq[(m_rr + k) % N].size() > 0) g = (m_rr + k) % N;
            end
            m_valid = (g >= 0);
            if (g >= 0) begin
                m_result = mq[g].pop_front();
                m_rr     = (g + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (v[i] && sz[i] < D) mq[i].push_back(bus.ex_result_rb0[i]);
            end
        end
    endtask

    // One clock cycle: drive at negedge, check ready, clock, advance model, check outputs.
    task automatic step(input logic [N-1:0] v, input logic fl, input logic rs);
        logic [N-1:0] rdy;
        reset     = rs;
        flush_rb1 = fl;
        for (int i = 0; i < N; i++) rdy[i] = !rs && (mq[i].size() < D);
        bus.ex_valid_rb0 = v & rdy;
        #1;
        check("ex_ready", 64'(bus.ex_ready_rb0), 64'(rdy));
        @(posedge clk);
        model(bus.ex_valid_rb0, fl, rs);
        @(negedge clk);
        check("ro_valid", 64'(bus.ro_valid_rb0), 64'(m_valid));
        check("ro_result", 64'(bus.ro_result_rb0), 64'(m_result));
    endtask

    typedef struct {
        logic [N-1:0] v;
        logic         rs;
        int           base;
        logic         exp_v;
        int           exp_id;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    int sat_v;
    int sat_src [N];
    int nout, first_v, last_v;

    initial begin
        reset            = 1'b1;
        flush_rb1        = 1'b0;
        bus.ex_valid_rb0 = '0;
        for (int i = 0; i < N; i++) bus.ex_result_rb0[i] = '0;
        m_rr     = 0;
        m_valid  = 1'b0;
        m_result = '0;

        // Single push, then simultaneous push from all sources with rr_ptr at 0.
        vecs[0] = '{v: 3'b000, rs: 1'b1, base: 0,  exp_v: 1'b0, exp_id: -1};
        vecs[1] = '{v: 3'b001, rs: 1'b0, base: 10, exp_v: 1'b0, exp_id: -1};
        vecs[2] = '{v: 3'b000, rs: 1'b0, base: 0,  exp_v: 1'b1, exp_id: 10};
        vecs[3] = '{v: 3'b000, rs: 1'b0, base: 0,  exp_v: 1'b0, exp_id: 10};
        vecs[4] = '{v: 3'b000, rs: 1'b1, base: 0,  exp_v: 1'b0, exp_id: -1};
        vecs[5] = '{v: 3'b111, rs: 1'b0, base: 20, exp_v: 1'b0, exp_id: -1};
        vecs[6] = '{v: 3'b000, rs: 1'b0, base: 0,  exp_v: 1'b1, exp_id: 20};
        vecs[7] = '{v: 3'b000, rs: 1'b0, base: 0,  exp_v: 1'b1, exp_id: 21};
        vecs[8] = '{v: 3'b000, rs: 1'b0, base: 0,  exp_v: 1'b1, exp_id: 22};
        vecs[9] = '{v: 3'b000, rs: 1'b0, base: 0,  exp_v: 1'b0, exp_id: 22};

        @(negedge clk);
        for (int r = 0; r < NV; r++) begin
            for (int i = 0; i < N; i++) bus.ex_result_rb0[i] = mk(vecs[r].base + i);
            step(vecs[r].v, 1'b0, vecs[r].rs);
            check($sformatf("vec%0d_valid", r), 64'(bus.ro_valid_rb0), 64'(vecs[r].exp_v));
            check($sformatf("vec%0d_result", r), 64'(bus.ro_result_rb0),
                  (vecs[r].exp_id < 0) ? 64'(0) : 64'(mk(vecs[r].exp_id)));
        end

        // Saturation: every source pushes whenever it may.
        step('0, 1'b0, 1'b1);
        sat_v = 0;
        for (int i = 0; i < N; i++) sat_src[i] = 0;
        for (int c = 0; c < 30; c++) begin
            for (int i = 0; i < N; i++) bus.ex_result_rb0[i] = mk(100 + 3 * c + i);
            step(3'b111, 1'b0, 1'b0);
            if (c >= 1 && bus.ro_valid_rb0) begin
                sat_v++;
                sat_src[(id_of(bus.ro_result_rb0) - 100) % 3]++;
            end
        end
        check("sat_valid_cycles", 64'(sat_v), 64'(29));
        check("sat_src0_grants", 64'(sat_src[0]), 64'(10));
        check("sat_src1_grants", 64'(sat_src[1]), 64'(10));
        check("sat_src2_grants", 64'(sat_src[2]), 64'(9));
        for (int c = 0; c < 8; c++) step('0, 1'b0, 1'b0);

        // Single-source stream of 8 back-to-back pushes on src1.
        nout    = 0;
        first_v = -1;
        last_v  = -1;
        for (int k = 0; k < 12; k++) begin
            bus.ex_result_rb0[1] = mk(200 + k);
            step((k < 8) ? 3'b010 : 3'b000, 1'b0, 1'b0);
            if (bus.ro_valid_rb0) begin
                check("stream_order", 64'(bus.ro_result_rb0), 64'(mk(200 + nout)));
                nout++;
                if (first_v < 0) first_v = k;
                last_v = k;
            end
        end
        check("stream_count", 64'(nout), 64'(8));
        check("stream_first", 64'(first_v), 64'(1));
        check("stream_last", 64'(last_v), 64'(8));

        // Flush with entries queued in src0/src2 while src1 pushes D.
        for (int i = 0; i < N; i++) bus.ex_result_rb0[i] = mk(300 + i);
        step(3'b101, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) bus.ex_result_rb0[i] = mk(303 + i);
        step(3'b101, 1'b0, 1'b0);
        bus.ex_result_rb0[0] = mk(306);
        step(3'b001, 1'b0, 1'b0);
        bus.ex_result_rb0[1] = mk(311);
        step(3'b010, 1'b1, 1'b0);
        check("flush_valid_f1", 64'(bus.ro_valid_rb0), 64'(0));
        check("flush_ready_f1", 64'(bus.ex_ready_rb0), 64'(3'b111));
        for (int c = 0; c < 4; c++) begin
            step('0, 1'b0, 1'b0);
            check("flush_no_output", 64'(bus.ro_valid_rb0), 64'(0));
        end

        // Reset mid-stream with several entries queued.
        for (int i = 0; i < N; i++) bus.ex_result_rb0[i] = mk(400 + i);
        step(3'b111, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) bus.ex_result_rb0[i] = mk(403 + i);
        step(3'b111, 1'b0, 1'b0);
        step('0, 1'b0, 1'b1);
        check("rst_valid", 64'(bus.ro_valid_rb0), 64'(0));
        check("rst_result", 64'(bus.ro_result_rb0), 64'(0));
        bus.ex_result_rb0[2] = mk(500);
        step(3'b100, 1'b0, 1'b0);
        check("rst_push_n1", 64'(bus.ro_valid_rb0), 64'(0));
        step('0, 1'b0, 1'b0);
        check("rst_push_n2_valid", 64'(bus.ro_valid_rb0), 64'(1));
        check("rst_push_n2_result", 64'(bus.ro_result_rb0), 64'(mk(500)));
        step('0, 1'b0, 1'b0);
        check("rst_push_n3", 64'(bus.ro_valid_rb0), 64'(0));

        // Randomized traffic with occasional flush and reset.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) bus.ex_result_rb0[i] = mk(int'($urandom));
            step(3'($urandom), ($urandom_range(0, 39) == 0), ($urandom_range(0, 199) == 0));
        end
        for (int c = 0; c < 6; c++) step('0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
